// File: rtl/writeback_stage.sv
// WB stage of the 5-stage MIPS pipeline: commits GPR writes, MTC0/MFC0, exceptions and ERET,
// and drives the CP0 bus, pipeline flush, forwarding info and the debug trace port.
module writeback_stage #(
    parameter int unsigned          DATA_WIDTH       = 32,
    parameter int unsigned          ADDR_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] EXCEPTION_VECTOR = 32'hbfc00380
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_to_wb_valid,
    output logic                  wb_allowin,
    input  logic [ADDR_WIDTH-1:0] mem_pc,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic                  mem_gpr_we,
    input  logic [4:0]            mem_dest,
    input  logic [1:0]            mem_cp0_op,
    input  logic [4:0]            mem_cp0_reg,
    input  logic [2:0]            mem_cp0_sel,
    input  logic [DATA_WIDTH-1:0] mem_rt_value,
    input  logic                  mem_exception_valid,
    input  logic [4:0]            mem_exception_code,
    input  logic                  mem_in_delay_slot,
    input  logic [DATA_WIDTH-1:0] cp0_read_data,
    input  logic [ADDR_WIDTH-1:0] cp0_epc,
    output logic [4:0]            cp0_address_register,
    output logic [2:0]            cp0_address_select,
    output logic                  cp0_write_enabled,
    output logic [DATA_WIDTH-1:0] cp0_write_data,
    output logic                  cp0_exception_valid,
    output logic [4:0]            cp0_exception_code,
    output logic [ADDR_WIDTH-1:0] cp0_exception_address,
    output logic                  cp0_in_delay_slot,
    output logic                  cp0_eret_flush,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_target,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  wb_fwd_valid,
    output logic [4:0]            wb_fwd_dest,
    output logic [ADDR_WIDTH-1:0] debug_wb_pc,
    output logic [3:0]            debug_wb_rf_wen,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [DATA_WIDTH-1:0] debug_wb_rf_wdata
);

    localparam logic [1:0] OpMfc0 = 2'b01;
    localparam logic [1:0] OpMtc0 = 2'b10;
    localparam logic [1:0] OpEret = 2'b11;

    typedef enum logic {PhaseWait, PhaseCommit} mfc0_phase_e;

    logic                  wb_valid_q, wb_valid_d;
    mfc0_phase_e           mfc0_phase_q, mfc0_phase_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  gpr_we_q, gpr_we_d;
    logic [4:0]            dest_q, dest_d;
    logic [1:0]            cp0_op_q, cp0_op_d;
    logic [4:0]            cp0_reg_q, cp0_reg_d;
    logic [2:0]            cp0_sel_q, cp0_sel_d;
    logic [DATA_WIDTH-1:0] rt_value_q, rt_value_d;
    logic                  exc_valid_q, exc_valid_d;
    logic [4:0]            exc_code_q, exc_code_d;
    logic                  bd_q, bd_d;

    logic live;
    logic is_mfc0;
    logic ready_go;
    logic commit;
    logic exc_commit;
    logic eret_commit;

    // Gating with reset keeps every output quiet during the reset cycle itself.
    assign live        = wb_valid_q && !reset;
    assign is_mfc0     = (cp0_op_q == OpMfc0);
    assign ready_go    = !(is_mfc0 && (mfc0_phase_q == PhaseWait));
    assign commit      = live && ready_go;
    assign exc_commit  = commit && exc_valid_q;
    assign eret_commit = commit && (cp0_op_q == OpEret) && !exc_valid_q;
    assign wb_allowin  = !reset && (!wb_valid_q || ready_go);

    always_comb begin
        wb_valid_d   = wb_valid_q;
        mfc0_phase_d = mfc0_phase_q;
        pc_d         = pc_q;
        result_d     = result_q;
        gpr_we_d     = gpr_we_q;
        dest_d       = dest_q;
        cp0_op_d     = cp0_op_q;
        cp0_reg_d    = cp0_reg_q;
        cp0_sel_d    = cp0_sel_q;
        rt_value_d   = rt_value_q;
        exc_valid_d  = exc_valid_q;
        exc_code_d   = exc_code_q;
        bd_d         = bd_q;

        if (commit) begin
            mfc0_phase_d = PhaseWait;
        end else if (live && is_mfc0 && (mfc0_phase_q == PhaseWait)) begin
            mfc0_phase_d = PhaseCommit;
            result_d     = cp0_read_data;
        end

        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (wb_allowin) begin
            wb_valid_d = mem_to_wb_valid;
            if (mem_to_wb_valid) begin
                pc_d        = mem_pc;
                result_d    = mem_result;
                gpr_we_d    = mem_gpr_we;
                dest_d      = mem_dest;
                cp0_op_d    = mem_cp0_op;
                cp0_reg_d   = mem_cp0_reg;
                cp0_sel_d   = mem_cp0_sel;
                rt_value_d  = mem_rt_value;
                exc_valid_d = mem_exception_valid;
                exc_code_d  = mem_exception_code;
                bd_d        = mem_in_delay_slot;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid_q   <= 1'b0;
            mfc0_phase_q <= PhaseWait;
            pc_q         <= '0;
            result_q     <= '0;
            gpr_we_q     <= 1'b0;
            dest_q       <= '0;
            cp0_op_q     <= '0;
            cp0_reg_q    <= '0;
            cp0_sel_q    <= '0;
            rt_value_q   <= '0;
            exc_valid_q  <= 1'b0;
            exc_code_q   <= '0;
            bd_q         <= 1'b0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            mfc0_phase_q <= mfc0_phase_d;
            pc_q         <= pc_d;
            result_q     <= result_d;
            gpr_we_q     <= gpr_we_d;
            dest_q       <= dest_d;
            cp0_op_q     <= cp0_op_d;
            cp0_reg_q    <= cp0_reg_d;
            cp0_sel_q    <= cp0_sel_d;
            rt_value_q   <= rt_value_d;
            exc_valid_q  <= exc_valid_d;
            exc_code_q   <= exc_code_d;
            bd_q         <= bd_d;
        end
    end

    assign cp0_address_register = live ? cp0_reg_q : '0;
    assign cp0_address_select   = live ? cp0_sel_q : '0;

    assign cp0_write_enabled = commit && (cp0_op_q == OpMtc0) && !exc_valid_q;
    assign cp0_write_data    = cp0_write_enabled ? rt_value_q : '0;

    // Raw PC goes out; CP0 applies the delay-slot adjustment itself.
    assign cp0_exception_valid   = exc_commit;
    assign cp0_exception_code    = exc_commit ? exc_code_q : '0;
    assign cp0_exception_address = exc_commit ? pc_q : '0;
    assign cp0_in_delay_slot     = exc_commit && bd_q;
    assign cp0_eret_flush        = eret_commit;

    assign flush        = exc_commit || eret_commit;
    assign flush_target = exc_commit  ? EXCEPTION_VECTOR :
                          eret_commit ? cp0_epc : '0;

    assign rf_we    = commit && gpr_we_q && !exc_valid_q && (dest_q != 5'd0);
    assign rf_waddr = rf_we ? dest_q : '0;
    assign rf_wdata = rf_we ? result_q : '0;

    // Stays up through the MFC0 wait so dependent instructions in ID stall.
    assign wb_fwd_valid = live && gpr_we_q && !exc_valid_q;
    assign wb_fwd_dest  = wb_fwd_valid ? dest_q : '0;

    assign debug_wb_pc       = live ? pc_q : '0;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final (WB) stage of the 5-stage MIPS pipeline, directly upstream of coprocessor 0. Latches one instruction from MEM and commits it: GPR write, CP0 write (MTC0), CP0 read (MFC0), exception entry or ERET. Drives the WB-to-CP0 bus, the pipeline flush request, forwarding info and the trace/debug port.

Parameters:
DATA_WIDTH, 32, GPR/CP0 data width
ADDR_WIDTH, 32, PC width
EXCEPTION_VECTOR, 32'hbfc00380, flush target on exception (BEV=1)

Ports:
clock  in  1  clock
reset  in  1  sync active-high reset
mem_to_wb_valid  in  1  MEM holds valid instr
wb_allowin  out  1  WB can accept this cycle
mem_pc  in  32  instr PC
mem_result  in  32  ALU/load result
mem_gpr_we  in  1  instr writes GPR
mem_dest  in  5  GPR dest
mem_cp0_op  in  2  00 none, 01 MFC0, 10 MTC0, 11 ERET
mem_cp0_reg  in  5  CP0 register number
mem_cp0_sel  in  3  CP0 select
mem_rt_value  in  32  MTC0 source data
mem_exception_valid  in  1  instr raised exception
mem_exception_code  in  5  ExcCode
mem_in_delay_slot  in  1  instr in branch delay slot
cp0_read_data  in  32  CP0 read result
cp0_epc  in  32  current EPC
cp0_address_register  out  5  CP0 bus address
cp0_address_select  out  3  CP0 bus select
cp0_write_enabled  out  1  MTC0 commit pulse
cp0_write_data  out  32  MTC0 data
cp0_exception_valid  out  1  exception commit pulse
cp0_exception_code  out  5  ExcCode
cp0_exception_address  out  32  faulting PC
cp0_in_delay_slot  out  1  BD flag
cp0_eret_flush  out  1  ERET commit pulse
flush  out  1  flush IF..MEM
flush_target  out  32  redirect PC
rf_we  out  1  GPR write enable
rf_waddr  out  5  GPR write address
rf_wdata  out  32  GPR write data
wb_fwd_valid  out  1  WB holds GPR-writing instr
wb_fwd_dest  out  5  its dest (0 if none)
debug_wb_pc  out  32  committed PC
debug_wb_rf_wen  out  4  byte write enables
debug_wb_rf_wnum  out  5  GPR number
debug_wb_rf_wdata  out  32  GPR data

Behaviour:
- State: wb_valid, mfc0_phase, latched instr fields. Reset: all 0; every output 0 during and after reset until a valid instr arrives.
- ready_go = !(op==MFC0 && !mfc0_phase). wb_allowin = !wb_valid || ready_go. commit = wb_valid && ready_go.
- Load: if wb_allowin && !flush, wb_valid <= mem_to_wb_valid and fields latched when valid. If flush, wb_valid <= 0 and the incoming instr is dropped.
- MFC0 FSM: LOAD -> WAIT (mfc0_phase=0: drive address, ready_go=0) -> COMMIT (mfc0_phase=1: result <= cp0_read_data, ready_go=1). mfc0_phase clears on commit or reset. Latency 2 cycles; other ops 1.
- cp0_address_register/select = latched reg/sel whenever wb_valid, else 0.
- GPR write: rf_we = commit && gpr_we && !exception && dest!=0. rf_wdata = result (MFC0: captured CP0 data).
- MTC0: cp0_write_enabled = commit && op==MTC0 && !exception; exactly one cycle; cp0_write_data = rt_value.
- Exception: cp0_exception_valid = commit && exception. Code, address=pc (raw, un-adjusted; CP0 applies delay-slot -4) and BD valid that cycle. Suppresses GPR, MTC0 and ERET effects.
- ERET: cp0_eret_flush = commit && op==ERET && !exception.
- flush = cp0_exception_valid || cp0_eret_flush. flush_target = EXCEPTION_VECTOR on exception, cp0_epc on ERET, else 0. Exception has priority.
- Forwarding: wb_fwd_valid = wb_valid && gpr_we && !exception; wb_fwd_dest = dest. Asserted during MFC0 WAIT, so ID stalls.
- Debug: debug_wb_pc = pc when wb_valid, debug_wb_rf_wen = {4{rf_we}}, wnum/wdata mirror rf.
- Reset mid-MFC0: FSM returns to empty; no CP0/GPR write issued.

Test Plan:
- ADDU pc=0xbfc00010, result 0x1234, dest 8, valid 1 cycle -> next cycle rf_we=1, waddr 8, wdata 0x1234, debug_wb_rf_wen=4'hf; wb_allowin stays 1.
- MFC0 reg 12 sel 0, cp0_read_data=0x00400001, back-to-back ADDU queued -> cycle1 wb_allowin=0, address 12/0, rf_we=0; cycle2 rf_wdata=0x00400001, allowin=1; ADDU commits cycle3.
- MTC0 reg 14 data 0xbfc00100 -> single-cycle cp0_write_enabled=1, data 0xbfc00100, rf_we=0, flush=0.
- Exception code 5'h0c, pc 0xbfc00024, in_delay_slot=1, gpr_we=1 -> cp0_exception_valid 1 cycle, address 0xbfc00024, BD=1, flush=1, flush_target 0xbfc00380, rf_we=0; instr offered by MEM same cycle dropped (no commit next cycle).
- ERET with cp0_epc=0xbfc00040 -> cp0_eret_flush=1, flush_target 0xbfc00040; ERET+exception together -> exception only, target 0xbfc00380.
- Reset asserted during MFC0 WAIT -> wb_valid=0, mfc0_phase=0, no rf_we/cp0 pulses; next instr commits normally.
